// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Data has priority; a streak counter forces a fetch grant after MAX_DSTREAK data grants.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [3:0] MAX_DS = 4'(MAX_DSTREAK);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;   // 1 = data port owns the outstanding access
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] dstreak_q, dstreak_d;
  logic       d_win, f_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      dstreak_q <= dstreak_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    dstreak_d = dstreak_q;
    d_win     = 1'b0;
    f_win     = 1'b0;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        d_win = d_req & (~if_req | (dstreak_q < MAX_DS));
        f_win = if_req & ~d_win;
        if (d_win) begin
          d_gnt     = 1'b1;
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          owner_d   = 1'b1;
          cnt_d     = LAT_M1;
          state_d   = S_WAIT;
          // d_win with if_req pending implies dstreak_q < MAX_DS, so no overflow here
          dstreak_d = if_req ? dstreak_q + 4'd1 : 4'd0;
        end else if (f_win) begin
          if_gnt    = 1'b1;
          mem_en    = 1'b1;
          mem_addr  = if_addr;
          owner_d   = 1'b0;
          cnt_d     = LAT_M1;
          state_d   = S_WAIT;
          dstreak_d = 4'd0;
        end else begin
          dstreak_d = 4'd0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (owner_q) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if_stall = if_req & ~if_gnt;
    d_stall  = d_req & ~d_gnt;
    busy     = (state_q == S_WAIT);

    // Outputs go quiet the moment reset is raised, not at the next edge.
    if (reset) begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      if_stall  = 1'b0;
      d_gnt     = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      d_stall   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
    end
  end

endmodule
